// File: rtl/l2_layer.sv
// Supervised output layer of the ODESA network: per-channel decaying traces,
// a 3-stage dot-product/winner pipeline and label-driven weight/threshold learning.
module l2_layer #(
  parameter int unsigned p_width   = 9,
  parameter int unsigned p_decay   = 16,
  parameter int unsigned p_eta     = 2,
  parameter int unsigned p_th_step = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [2:1]             i_event,
  input  logic [4:1]             i_label,
  input  logic                   i_endof_epochs,
  output logic [2*p_width-1:0]   o_tr,
  output logic                   o_las,
  output logic                   o_gas,
  output logic [4:1]             o_spike_out
);

  localparam int unsigned W    = p_width;
  localparam int unsigned PW   = 2 * p_width;
  localparam int unsigned DW   = 2 * p_width + 1;
  localparam int unsigned SW   = p_width + 2;
  localparam int unsigned TMAX = (1 << p_width) - 1;
  localparam int unsigned NN   = 4;

  logic [W-1:0]  tr [2];
  logic [W-1:0]  w  [NN][2];
  logic [DW-1:0] th [NN];

  logic          ev_q;
  logic [3:0]    lbl_q;
  logic          s1_vld;
  logic [3:0]    s1_lbl;
  logic [W-1:0]  s1_tr [2];
  logic          s2_vld;
  logic [3:0]    s2_lbl;
  logic [W-1:0]  s2_tr [2];
  logic [DW-1:0] s2_dot [NN];

  logic [1:0]    ev;
  logic          lbl_onehot;
  logic [3:0]    lbl_in;

  logic [DW-1:0] dot     [NN];
  logic [NN-1:0] qual;
  logic [DW-1:0] best;
  logic          found;
  logic [1:0]    win_idx;
  logic [NN-1:0] win_oh;
  logic [DW-1:0] th_hit  [NN];
  logic [DW-1:0] th_miss [NN];
  logic [W-1:0]  nxt_w   [NN][2];

  // Move a weight a 1/2^eta step toward the trace, kept inside [0, TMAX].
  function automatic logic [W-1:0] learn_w(input logic [W-1:0] wv, input logic [W-1:0] tv);
    logic signed [SW-1:0] diff;
    logic signed [SW-1:0] sum;
    diff = $signed({2'b00, tv}) - $signed({2'b00, wv});
    sum  = $signed({2'b00, wv}) + (diff >>> p_eta);
    if (sum[SW-1])                       return '0;
    else if (sum > $signed(SW'(TMAX)))   return W'(TMAX);
    else                                 return W'(sum);
  endfunction

  assign ev         = i_event;
  assign o_tr       = {tr[1], tr[0]};
  assign lbl_onehot = (i_label != 4'd0) && ((i_label & (i_label - 4'd1)) == 4'd0);
  assign lbl_in     = (lbl_onehot && !i_endof_epochs) ? i_label : 4'd0;

  always_comb begin
    found   = 1'b0;
    best    = '0;
    win_idx = 2'd0;
    qual    = '0;
    for (int k = 0; k < NN; k++) begin
      dot[k]     = DW'(PW'(w[k][0]) * PW'(s1_tr[0])) + DW'(PW'(w[k][1]) * PW'(s1_tr[1]));
      qual[k]    = (s2_dot[k] >= th[k]);
      th_hit[k]  = th[k] + ((s2_dot[k] - th[k]) >> p_eta);
      th_miss[k] = (th[k] > DW'(p_th_step)) ? th[k] - DW'(p_th_step) : '0;
      for (int c = 0; c < 2; c++) nxt_w[k][c] = learn_w(w[k][c], s2_tr[c]);
      // Strict compare keeps the lowest index on ties.
      if (qual[k] && (!found || (s2_dot[k] > best))) begin
        found   = 1'b1;
        best    = s2_dot[k];
        win_idx = 2'(k);
      end
    end
    win_oh = found ? (4'd1 << win_idx) : 4'd0;
  end

  // Traces: reload on spike, otherwise saturating linear decay.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < 2; c++) tr[c] <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (ev[c])                        tr[c] <= W'(TMAX);
        else if (tr[c] > W'(p_decay))     tr[c] <= tr[c] - W'(p_decay);
        else                              tr[c] <= '0;
      end
    end
  end

  // Event pipeline, winner selection and learning.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ev_q        <= 1'b0;
      lbl_q       <= '0;
      s1_vld      <= 1'b0;
      s1_lbl      <= '0;
      s2_vld      <= 1'b0;
      s2_lbl      <= '0;
      o_spike_out <= '0;
      o_gas       <= 1'b0;
      o_las       <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        s1_tr[c] <= '0;
        s2_tr[c] <= '0;
      end
      for (int k = 0; k < NN; k++) begin
        s2_dot[k] <= '0;
        th[k]     <= '0;
        for (int c = 0; c < 2; c++) w[k][c] <= W'(TMAX >> 1);
      end
    end else begin
      ev_q   <= |i_event;
      lbl_q  <= lbl_in;
      s1_vld <= ev_q;
      s1_lbl <= lbl_q;
      s2_vld <= s1_vld;
      s2_lbl <= s1_lbl;
      for (int c = 0; c < 2; c++) begin
        s1_tr[c] <= tr[c];
        s2_tr[c] <= s1_tr[c];
      end
      for (int k = 0; k < NN; k++) s2_dot[k] <= dot[k];

      o_spike_out <= s2_vld ? win_oh : 4'd0;
      o_gas       <= s2_vld && (s2_lbl != 4'd0);
      o_las       <= s2_vld && ((s2_lbl & qual) != 4'd0);

      // Only the labelled neuron learns, whichever neuron won.
      for (int k = 0; k < NN; k++) begin
        if (s2_vld && s2_lbl[k]) begin
          if (qual[k]) begin
            th[k] <= th_hit[k];
            for (int c = 0; c < 2; c++) w[k][c] <= nxt_w[k][c];
          end else begin
            th[k] <= th_miss[k];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_l2_layer.sv
// Directed bench for l2_layer: reset, trace decay, first learning steps,
// threshold miss, mid-run reset, four-pattern training and frozen inference.
module tb_l2_layer;

  logic        i_clk;
  logic        i_rst;
  logic [2:1]  i_event;
  logic [4:1]  i_label;
  logic        i_endof_epochs;
  logic [17:0] o_tr;
  logic        o_las;
  logic        o_gas;
  logic [4:1]  o_spike_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:1] pe1  [4] = '{2'b01, 2'b01, 2'b10, 2'b10};
  logic [2:1] pe2  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [4:1] plbl [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  int unsigned wexp [4][2] = '{'{508, 0}, '{316, 508}, '{508, 316}, '{0, 508}};

  l2_layer dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_event        (i_event),
    .i_label        (i_label),
    .i_endof_epochs (i_endof_epochs),
    .o_tr           (o_tr),
    .o_las          (o_las),
    .o_gas          (o_gas),
    .o_spike_out    (o_spike_out)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present an event for exactly one rising edge; call at a falling edge.
  task automatic send(input logic [2:1] ev, input logic [4:1] lbl);
    i_event = ev;
    i_label = lbl;
    @(negedge i_clk);
    i_event = '0;
    i_label = '0;
  endtask

  // Send one event, then sample the pipeline outputs just after the third edge.
  task automatic send_and_wait(input logic [2:1] ev, input logic [4:1] lbl);
    send(ev, lbl);
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  task automatic run_pattern(input int p, input bit do_check, input logic exp_att, input string tag);
    send(pe1[p], 4'b0000);
    repeat (11) @(negedge i_clk);
    send_and_wait(pe2[p], plbl[p]);
    if (do_check) begin
      check({tag, "_spike"}, 32'(o_spike_out), 32'(plbl[p]));
      check({tag, "_las"},   32'(o_las),       32'(exp_att));
      check({tag, "_gas"},   32'(o_gas),       32'(exp_att));
    end
    repeat (40) @(negedge i_clk);
  endtask

  task automatic check_weights(input string tag);
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 2; c++)
        check($sformatf("%s_w%0d%0d", tag, k + 1, c + 1), 32'(dut.w[k][c]), 32'(wexp[k][c]));
  endtask

  initial begin
    i_rst          = 1'b1;
    i_event        = '0;
    i_label        = '0;
    i_endof_epochs = 1'b0;
    #1;
    check("rst_tr",    32'(o_tr),        32'd0);
    check("rst_spike", 32'(o_spike_out), 32'd0);
    check("rst_las",   32'(o_las),       32'd0);
    check("rst_gas",   32'(o_gas),       32'd0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);

    // Trace decay on channel 1 only.
    send(2'b01, 4'b0000);
    check("decay_k0", 32'(o_tr), 32'd511);
    @(negedge i_clk);
    check("decay_k1", 32'(o_tr), 32'd495);
    repeat (30) @(negedge i_clk);
    check("decay_k31", 32'(o_tr), 32'd15);
    @(negedge i_clk);
    check("decay_k32", 32'(o_tr), 32'd0);
    repeat (20) @(negedge i_clk);

    // First labelled event: every neuron ties, neuron 1 wins and learns.
    send_and_wait(2'b01, 4'b0001);
    check("l1_spike", 32'(o_spike_out), 32'd1);
    check("l1_gas",   32'(o_gas),       32'd1);
    check("l1_las",   32'(o_las),       32'd1);
    check("l1_w11",   32'(dut.w[0][0]), 32'd319);
    check("l1_w12",   32'(dut.w[0][1]), 32'd191);
    check("l1_th1",   32'(dut.th[0]),   32'd32576);
    @(posedge i_clk);
    #1;
    check("l1_gas_drop",   32'(o_gas),       32'd0);
    check("l1_las_drop",   32'(o_las),       32'd0);
    check("l1_spike_drop", 32'(o_spike_out), 32'd0);
    @(negedge i_clk);
    repeat (40) @(negedge i_clk);

    send_and_wait(2'b01, 4'b0001);
    check("l2_spike", 32'(o_spike_out), 32'd1);
    check("l2_w11",   32'(dut.w[0][0]), 32'd367);
    check("l2_th1",   32'(dut.th[0]),   32'd65184);
    @(negedge i_clk);
    repeat (40) @(negedge i_clk);

    send_and_wait(2'b01, 4'b0001);
    check("l3_spike", 32'(o_spike_out), 32'd1);
    check("l3_w12",   32'(dut.w[0][1]), 32'd107);
    check("l3_th1",   32'(dut.th[0]),   32'd95772);
    @(negedge i_clk);
    repeat (40) @(negedge i_clk);

    // Channel-2 event labelled for neuron 1 cannot reach its threshold.
    send_and_wait(2'b10, 4'b0001);
    check("miss_spike", 32'(o_spike_out), 32'd2);
    check("miss_las",   32'(o_las),       32'd0);
    check("miss_gas",   32'(o_gas),       32'd1);
    check("miss_th1",   32'(dut.th[0]),   32'd95708);
    check("miss_w12",   32'(dut.w[0][1]), 32'd107);
    @(negedge i_clk);
    repeat (40) @(negedge i_clk);

    // Reset with an event in flight.
    send(2'b01, 4'b0000);
    repeat (2) @(posedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    check("mrst_tr",    32'(o_tr),         32'd0);
    check("mrst_spike", 32'(o_spike_out),  32'd0);
    check("mrst_las",   32'(o_las),        32'd0);
    check("mrst_gas",   32'(o_gas),        32'd0);
    check("mrst_w11",   32'(dut.w[0][0]),  32'd255);
    check("mrst_th1",   32'(dut.th[0]),    32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    check("mrst_no_spike", 32'(o_spike_out), 32'd0);
    @(negedge i_clk);
    repeat (40) @(negedge i_clk);

    // Training: each pattern repeated 64 times, checked on the last repeat.
    for (int p = 0; p < 4; p++)
      for (int r = 0; r < 64; r++)
        run_pattern(p, r == 63, 1'b1, $sformatf("train_p%0d", p));
    check_weights("train");

    // Inference: learning frozen, spikes unchanged.
    i_endof_epochs = 1'b1;
    for (int p = 0; p < 4; p++)
      run_pattern(p, 1'b1, 1'b0, $sformatf("infer_p%0d", p));
    check_weights("infer");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
